ines_loader: RTL

Streaming iNES image loader that sits directly upstream of the NES system top level. It accepts a cartridge file as a byte stream and parses the 16-byte iNES header. It drives the ROM programmer port (PRG/CHR write strobes, address, data) and the header-derived `is_chr_ram` / `mirroring_mode` signals, and holds the console in reset until the image is fully loaded. Mapper 0 (NROM) images only.

---
 rtl/nes_loader_pkg.sv | 30 +++
 rtl/ines_header_check.sv | 54 +++++
 rtl/ines_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/nes_loader_pkg.sv
// rtl/nes_loader_pkg.sv - shared states, iNES constants and magic-byte lookup for the image loader
package nes_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_TRAINER,
    ST_PRG,
    ST_CHR,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [31:0] INES_MAGIC    = 32'h4E45531A;
  localparam int          HEADER_LEN    = 16;
  localparam int          TRAINER_LEN   = 512;
  localparam int          PRG_BANK_SIZE = 16384;
  localparam int          CHR_BANK_SIZE = 8192;

  // Byte 0 of the file is the most significant byte of INES_MAGIC.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return INES_MAGIC[31:24];
      2'd1:    return INES_MAGIC[23:16];
      2'd2:    return INES_MAGIC[15:8];
      default: return INES_MAGIC[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ines_header_check.sv
// rtl/ines_header_check.sv - latches iNES header fields by byte index and judges the header
// Optional magic-number check: INES_MAGIC_CHECK_EN.
module ines_header_check
  import nes_loader_pkg::*;
#(
  parameter int PRG_MAX_BANKS = 2,
  parameter int CHR_MAX_BANKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       byte_en,
  input  logic [3:0] byte_idx,
  input  logic [7:0] byte_data,
  output logic [7:0] prg_banks,
  output logic [7:0] chr_banks,
  output logic       mirror,
  output logic       trainer,
  output logic       header_ok
);

  logic magic_bad;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prg_banks <= 8'd0;
      chr_banks <= 8'd0;
      mirror    <= 1'b0;
      trainer   <= 1'b0;
      magic_bad <= 1'b0;
    end else if (byte_en) begin
      case (byte_idx)
        4'd4:    prg_banks <= byte_data;
        4'd5:    chr_banks <= byte_data;
        4'd6: begin
          mirror  <= byte_data[0];
          trainer <= byte_data[2];
        end
        default: ;
      endcase
`ifdef INES_MAGIC_CHECK_EN
      // Sticky: one bad magic byte is enough to reject at the end of the header.
      if (byte_idx < 4'd4 && byte_data != magic_byte(byte_idx[1:0]))
        magic_bad <= 1'b1;
`endif
    end
  end

  assign header_ok = (prg_banks != 8'd0) &&
                     (int'(prg_banks) <= PRG_MAX_BANKS) &&
                     (int'(chr_banks) <= CHR_MAX_BANKS) &&
                     !magic_bad;

endmodule

// File: rtl/ines_loader.sv
// rtl/ines_loader.sv - streaming NROM iNES loader driving the PRG/CHR ROM programmer port
// Holds the console in reset until the image is fully written.
module ines_loader
  import nes_loader_pkg::*;
#(
  parameter int PRG_MAX_BANKS = 2,
  parameter int CHR_MAX_BANKS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        prg_rom_prgmr_wren,
  output logic        chr_rom_prgmr_wren,
  output logic [15:0] rom_prgmr_addr,
  output logic [7:0]  rom_prgmr_data,
  output logic        is_chr_ram,
  output logic        mirroring_mode,
  output logic        load_done,
  output logic        load_error,
  output logic        nes_reset_hold
);

  state_t      state;
  logic [14:0] cnt;
  logic [14:0] prg_last;
  logic        xfer;
  logic [7:0]  prg_banks;
  logic [7:0]  chr_banks;
  logic        hdr_mirror;
  logic        hdr_trainer;
  logic        header_ok;

  assign in_ready = (state inside {ST_HEADER, ST_TRAINER, ST_PRG, ST_CHR}) && !start;
  assign xfer     = in_valid && in_ready;
  assign prg_last = 15'(int'(prg_banks) * PRG_BANK_SIZE - 1);

  ines_header_check #(
    .PRG_MAX_BANKS(PRG_MAX_BANKS),
    .CHR_MAX_BANKS(CHR_MAX_BANKS)
  ) u_header_check (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .byte_en  (xfer && state == ST_HEADER),
    .byte_idx (cnt[3:0]),
    .byte_data(in_data),
    .prg_banks(prg_banks),
    .chr_banks(chr_banks),
    .mirror   (hdr_mirror),
    .trainer  (hdr_trainer),
    .header_ok(header_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      cnt                <= 15'd0;
      prg_rom_prgmr_wren <= 1'b0;
      chr_rom_prgmr_wren <= 1'b0;
      rom_prgmr_addr     <= 16'd0;
      rom_prgmr_data     <= 8'd0;
      is_chr_ram         <= 1'b0;
      mirroring_mode     <= 1'b0;
    end else begin
      prg_rom_prgmr_wren <= 1'b0;
      chr_rom_prgmr_wren <= 1'b0;
      if (start) begin
        state <= ST_HEADER;
        cnt   <= 15'd0;
      end else if (xfer) begin
        cnt <= cnt + 15'd1;
        case (state)
          ST_HEADER: begin
            if (cnt == 15'(HEADER_LEN - 1)) begin
              cnt <= 15'd0;
              if (header_ok) begin
                is_chr_ram     <= (chr_banks == 8'd0);
                mirroring_mode <= hdr_mirror;
                state          <= hdr_trainer ? ST_TRAINER : ST_PRG;
              end else begin
                state <= ST_ERROR;
              end
            end
          end
          ST_TRAINER: begin
            if (cnt == 15'(TRAINER_LEN - 1)) begin
              cnt   <= 15'd0;
              state <= ST_PRG;
            end
          end
          ST_PRG: begin
            prg_rom_prgmr_wren <= 1'b1;
            rom_prgmr_addr     <= {1'b0, cnt};
            rom_prgmr_data     <= in_data;
            if (cnt == prg_last) begin
              cnt   <= 15'd0;
              state <= (chr_banks == 8'd1) ? ST_CHR : ST_DONE;
            end
          end
          ST_CHR: begin
            chr_rom_prgmr_wren <= 1'b1;
            rom_prgmr_addr     <= {3'b000, cnt[12:0]};
            rom_prgmr_data     <= in_data;
            if (cnt == 15'(CHR_BANK_SIZE - 1)) begin
              cnt   <= 15'd0;
              state <= ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The state register is already one cycle behind the accepting edge, so these
  // line up with the final write strobe and with the cycle after header byte 15.
  assign load_done      = (state == ST_DONE);
  assign load_error     = (state == ST_ERROR);
  assign nes_reset_hold = (state != ST_DONE);

endmodule
